bin_to_bcd_formatter: RTL and testbench
=======================================

BIN_TO_BCD_FORMATTER -- requirements
Module: bin_to_bcd_formatter

Interface
REQ-001 Parameter BIN_WIDTH, default 27: width of the binary operand; legal range 1..27.
REQ-002 Port clk_in, input, 1: single clock; all state changes on its rising edge.
REQ-003 Port rst_in, input, 1: reset, synchronous, active-low.
REQ-004 Port valid_in, input, 1: request to convert bin_in.
REQ-005 Port ready_out, output, 1: block is idle and accepts a request this cycle.
REQ-006 Port bin_in, input, BIN_WIDTH: unsigned binary operand.
REQ-007 Port hex_mode_in, input, 1: 1 = hex passthrough, 0 = decimal conversion; sampled with bin_in.
REQ-008 Port val_out, output, 32: eight 4-bit digits, digit i at [4i+3:4i], digit 0 least significant; drives the seven-segment controller's 32-bit value input.
REQ-009 Port valid_out, output, 1: one-cycle pulse marking a new val_out.
REQ-010 Port overflow_out, output, 1: the last result overflowed 8 decimal digits.

Function
REQ-011 A request is accepted on a rising edge where valid_in=1 and ready_out=1; bin_in and hex_mode_in are captured at that edge only.
REQ-012 ready_out SHALL equal 1 exactly when the state is IDLE.
REQ-013 The state machine SHALL have the states IDLE, SHIFT and FINISH.
REQ-014 Transitions:
- IDLE -> SHIFT on accept with hex_mode_in=0.
- IDLE -> FINISH on accept with hex_mode_in=1.
- SHIFT -> FINISH after BIN_WIDTH iterations.
- FINISH -> IDLE unconditionally.
REQ-015 On a decimal accept: shift register loads bin_in, BCD accumulator clears to 0, iteration counter clears to 0.
REQ-016 Each SHIFT cycle performs one double-dabble iteration.
- Add 3 to every BCD digit that is >= 5.
- Shift {accumulator, shift register} left by 1; the MSB of the shift register enters accumulator bit 0.
REQ-017 Iterations occur on the BIN_WIDTH edges following the accept edge; the counter is BIN_WIDTH-1 on the last one.
REQ-018 On the FINISH edge: val_out and overflow_out are updated and valid_out is set to 1; on every other edge valid_out is 0.
REQ-019 Decimal latency: val_out/valid_out change on edge BIN_WIDTH+1 after the accept edge (edge 28 for the default).
REQ-020 Hex latency: val_out/valid_out change on edge 1 after the accept edge.
REQ-021 Hex result: val_out = bin_in zero-extended to 32 bits; overflow_out = 0.
REQ-022 Overflow: in decimal mode a captured operand >= 100_000_000 SHALL set a stored flag.
- Iterations still run, so latency is unchanged.
- At FINISH: val_out = 32'hFFFF_FFFF, overflow_out = 1.
REQ-023 Decimal result without overflow: val_out = 8-digit BCD of the operand, leading zeros included; overflow_out = 0.
REQ-024 val_out and overflow_out SHALL hold their last value between results, so the display stays stable.
REQ-025 valid_in while ready_out=0 is ignored and not queued, regardless of whether valid_in is held or pulsed.
REQ-026 A new request may be accepted in the IDLE cycle in which valid_out=1; back-to-back decimal throughput is one result per BIN_WIDTH+2 cycles.
REQ-027 The BCD accumulator is 32 bits; any carry out of bit 31 is discarded (reachable only in the overflow case, whose output is overridden).

Reset
REQ-028 When rst_in=0 at a rising edge, on that edge:
- state = IDLE
- val_out = 32'h0000_0000
- valid_out = 0
- overflow_out = 0
- counter, shift register, accumulator and overflow flag = 0
REQ-029 Reset during SHIFT or FINISH SHALL abort the conversion with no valid_out pulse; ready_out = 1 on the first cycle after release.

Verification
REQ-030 The bench SHALL cover these directed scenarios (BIN_WIDTH=27):
- Decimal 12_345_678 -> val_out=32'h1234_5678, overflow_out=0, valid_out high exactly 1 cycle, 28 edges after accept.
- Decimal 0 -> 32'h0000_0000; decimal 99_999_999 -> 32'h9999_9999, overflow_out=0.
- Decimal 100_000_000 and 134_217_727 -> 32'hFFFF_FFFF, overflow_out=1, latency 28.
- Hex mode bin_in=27'h3AB_CDEF -> val_out=32'h03AB_CDEF on edge 1, overflow_out=0.
- valid_in held high with 5 then 7 during one conversion -> exactly two results (5 then 7), second accepted in the valid_out cycle of the first; val_out unchanged until each FINISH.
- rst_in=0 at edge 10 of a conversion -> val_out=0, no valid_out pulse, ready_out=1 next cycle; a following request for 42 -> 32'h0000_0042.

Source files
------------

// File: rtl/bin_to_bcd_formatter.sv
// Binary to 8-digit BCD formatter for a seven-segment display driver.
// Decimal mode runs a serial double-dabble; hex mode passes the operand through.
module bin_to_bcd_formatter #(
    parameter int BIN_WIDTH = 27
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic [BIN_WIDTH-1:0] bin_in,
    input  logic                 hex_mode_in,
    output logic [31:0]          val_out,
    output logic                 valid_out,
    output logic                 overflow_out
);

    localparam int CW = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIN_WIDTH - 1);
    localparam logic [31:0] DEC_LIMIT = 32'd100_000_000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BIN_WIDTH-1:0] sh_q, sh_d;
    logic [31:0]          acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic [31:0]          val_q, val_d;
    logic                 vout_q, vout_d;
    logic                 oflow_q, oflow_d;

    logic [31:0]          bin_ext;
    logic [31:0]          adj;

    assign bin_ext = {{(32 - BIN_WIDTH){1'b0}}, bin_in};

    // Digits >= 5 get +3 so the following shift carries correctly into the next digit.
    always_comb begin
        adj = acc_q;
        for (int i = 0; i < 8; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        val_d   = val_q;
        vout_d  = 1'b0;
        oflow_d = oflow_q;
        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (hex_mode_in) begin
                        acc_d   = bin_ext;
                        ovf_d   = 1'b0;
                        state_d = FINISH;
                    end else begin
                        sh_d    = bin_in;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = (bin_ext >= DEC_LIMIT);
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                acc_d = {adj[30:0], sh_q[BIN_WIDTH-1]};
                sh_d  = sh_q << 1;
                if (cnt_q == LAST) begin
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FINISH: begin
                vout_d  = 1'b1;
                val_d   = ovf_q ? 32'hFFFF_FFFF : acc_q;
                oflow_d = ovf_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            val_q   <= '0;
            vout_q  <= 1'b0;
            oflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            val_q   <= val_d;
            vout_q  <= vout_d;
            oflow_q <= oflow_d;
        end
    end

    assign ready_out    = (state_q == IDLE);
    assign val_out      = val_q;
    assign valid_out    = vout_q;
    assign overflow_out = oflow_q;

endmodule

// File: tb/tb_bin_to_bcd_formatter.sv
// Scoreboard bench for bin_to_bcd_formatter: queued expectations from an
// arithmetic reference model, checked by an independent output monitor.
module tb_bin_to_bcd_formatter;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic [26:0] bin_in = '0;
    logic        hex_mode_in = 1'b0;
    logic [31:0] val_out;
    logic        valid_out;
    logic        overflow_out;

    bin_to_bcd_formatter #(.BIN_WIDTH(27)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .bin_in       (bin_in),
        .hex_mode_in  (hex_mode_in),
        .val_out      (val_out),
        .valid_out    (valid_out),
        .overflow_out (overflow_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] v;
        logic        o;
        int          e;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          mon_hold = 1'b1;
    logic [31:0] last_val = '0;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [31:0] ref_val(input int unsigned b, input bit h);
        logic [31:0] r;
        int unsigned p;
        if (h) return b;
        if (b >= 100_000_000) return 32'hFFFF_FFFF;
        r = '0;
        p = b;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(p % 10);
            p = p / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per valid_out pulse; val_out must be stable otherwise.
    always @(negedge clk_in) begin
        if (valid_out) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result: got val=%h at edge %0d, none pending",
                         val_out, cyc);
            end else begin
                exp_t x;
                x = q.pop_front();
                if (val_out !== x.v || overflow_out !== x.o || cyc != x.e) begin
                    bad++;
                    $display("FAIL result: got val=%h ovf=%b edge=%0d want val=%h ovf=%b edge=%0d",
                             val_out, overflow_out, cyc, x.v, x.o, x.e);
                end
            end
        end else if (!mon_hold) begin
            total++;
            if (val_out !== last_val) begin
                bad++;
                $display("FAIL hold: got val=%h want %h at edge %0d", val_out, last_val, cyc);
            end
        end
        last_val = val_out;
    end

    task automatic send(input int unsigned b, input bit h, input bit drop);
        int n;
        exp_t x;
        @(negedge clk_in);
        valid_in    = 1'b1;
        bin_in      = 27'(b);
        hex_mode_in = h;
        n = 0;
        while (!ready_out && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        if (!ready_out) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got ready=0 want 1");
        end else begin
            x.v = ref_val(b, h);
            x.o = !h && (b >= 100_000_000);
            x.e = cyc + 1 + (h ? 1 : 28);
            q.push_back(x);
        end
        @(posedge clk_in);
        #1;
        if (drop) valid_in = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        repeat (2) @(negedge clk_in);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        int unsigned b;
        bit h;
        repeat (2) @(posedge clk_in);
        #1;
        check("reset_val", val_out, 32'h0);
        check("reset_valid", {31'b0, valid_out}, 32'h0);
        check("reset_ovf", {31'b0, overflow_out}, 32'h0);
        check("reset_ready", {31'b0, ready_out}, 32'h1);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        mon_hold = 1'b0;

        send(12_345_678, 0, 1);
        drain();
        send(0, 0, 1);
        send(99_999_999, 0, 1);
        send(100_000_000, 0, 1);
        send(134_217_727, 0, 1);
        send(27'h3AB_CDEF, 1, 1);
        send(1, 0, 1);
        drain();

        // Held valid: 7 replaces 5 mid-conversion and is taken in the result cycle.
        send(5, 0, 0);
        send(7, 0, 1);
        drain();

        // Reset lands on edge 10 of a conversion.
        send(999, 0, 1);
        repeat (9) @(negedge clk_in);
        mon_hold = 1'b1;
        rst_in = 1'b0;
        q.delete();
        @(posedge clk_in);
        #1;
        check("abort_val", val_out, 32'h0);
        check("abort_valid", {31'b0, valid_out}, 32'h0);
        check("abort_ovf", {31'b0, overflow_out}, 32'h0);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        check("abort_ready", {31'b0, ready_out}, 32'h1);
        check("abort_novalid", {31'b0, valid_out}, 32'h0);
        @(negedge clk_in);
        mon_hold = 1'b0;
        send(42, 0, 1);
        drain();

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0: b = $urandom_range(0, 99_999_999);
                1: b = $urandom_range(99_999_990, 100_000_010);
                2: b = $urandom_range(0, 999);
                default: b = $urandom_range(0, 134_217_727);
            endcase
            h = ($urandom_range(0, 3) == 0);
            send(b, h, ($urandom_range(0, 1) == 1));
            valid_in = 1'b0;
        end
        drain();
        repeat (40) @(negedge clk_in);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
